photo_frame_master: RTL and testbench
=====================================

Name: photo_frame_master

Overview:
- Master-side reader for the shared 8-bit address/data bus that the 64-bit light-curtain slave chips sit on.
- Watches every slave's active-low capture flag (enwipe) and reads each pending slave's latched 64-bit snapshot byte by byte over the tri-state data bus.
- Presents each snapshot as one frame on a valid/ready output toward the position-computation logic.
- Issues the 8'hFF release broadcast only after all pending slaves have been read, so no capture is lost.

Parameters:
NSLAVE, 7, number of slaves on the bus (IDs 0..NSLAVE-1); legal range 1..7. ID 7 is reserved because address 8'hFF (ID 7, byte 7) is the release code.
IDLE_ADDR, 8'hE0, address driven whenever no read or release is in progress. It selects unused ID 7 byte 0 and is never 8'hFF.

Ports:
clkin  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
enwipein  input  NSLAVE  per-slave capture flag; 0 = slave holds an unread snapshot
csin  input  NSLAVE  per-slave chip-select echo; 1 = slave is responding to an address
datain  input  8  shared tri-state data bus from the slaves
address  output  8  bus address: [7:5] slave ID, [4:3] = 0, [2:0] byte index (0 = bits 7:0 ... 7 = bits 63:56)
frame_data  output  64  assembled snapshot
frame_id  output  3  ID of the slave the frame came from
frame_valid  output  1  frame available
frame_ready  input  1  consumer accepts the frame
busy  output  1  1 whenever state is not IDLE
err  output  1  sticky bus error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clkin. Reset is asynchronous and active-low on rstn.
- Reset values: address = IDLE_ADDR, frame_data = 0, frame_id = 0, frame_valid = 0, busy = 0, err = 0, served mask = 0, state = IDLE.
- Reset asserted mid-operation: all of the above apply immediately (asynchronously). Slaves keep their snapshots and are re-read after reset.
- Pending mask: pending = ~enwipein & ~served, using bits 0..NSLAVE-1 only.
- IDLE:
  - pending != 0: pick the lowest set index T, drive address = {T, 2'b00, 3'd0} at this edge, go to READ.
  - pending == 0 and served != 0: go to RELEASE.
  - otherwise: stay in IDLE.
- READ (slave output is registered on address, so latency is 2 cycles):
  - Let edge e be the one that drove byte 0. Byte k's address is driven at edge e+k, for k = 0..7.
  - The byte-7 address is held through edge e+8.
  - datain is captured for byte k at edge e+k+2.
- Frame output:
  - At edge e+9: load frame_data with the 8 captured bytes, set frame_id = T, set frame_valid = 1, set served[T] = 1, set address = IDLE_ADDR, go to OUT.
- OUT:
  - Hold frame_valid, frame_data and frame_id stable until frame_valid & frame_ready is seen at an edge.
  - On that edge: frame_valid = 0, go to IDLE (re-evaluates pending). The minimum slave-to-slave spacing is 11 cycles.
  - If frame_ready is already 1 when frame_valid rises, the transfer completes on the next edge.
- RELEASE:
  - Drive address = 8'hFF for exactly one cycle.
  - Next edge: address = IDLE_ADDR, served = 0, go to WAIT.
- WAIT: one cycle, so the slaves' enwipe deassertion is visible; then go to IDLE.
- Slaves that assert enwipe during a batch are picked up through pending before RELEASE. Exactly one 8'hFF is issued per batch.
- Invariant: address never equals 8'hFF outside RELEASE.
- A slave that drops enwipe in the same cycle 8'hFF is sampled is released by the broadcast; that capture loss is accepted.

Optional Feature:
- CS_CHECK_EN defined:
  - At every byte capture in READ, csin[T] must be 1; otherwise err is set to 1.
  - At the edge e+9, enwipein[T] must be 0; otherwise err is set to 1.
  - err is sticky until reset. The frame is still delivered.
- CS_CHECK_EN not defined: err is tied to 0 and csin is unused.

Test Plan:
- Slave 2 holds 64'h0123_4567_89AB_CDEF and its enwipe falls:
  - address steps 8'h40..8'h47, with 8'h47 held 2 cycles;
  - frame_valid rises 9 cycles after 8'h40 is driven, with frame_data = 64'h0123_4567_89AB_CDEF and frame_id = 2;
  - then address = 8'hFF for exactly one cycle, then 8'hE0.
- Slaves 0 and 5 go low in the same cycle: frames are delivered with ID 0 then ID 5, and a single 8'hFF follows the second frame.
- Slave 4 goes low while slave 1 is in READ: both frames are delivered (1 then 4) before one 8'hFF; no 8'hFF appears between them.
- frame_ready is held 0 for 5 cycles after frame_valid:
  - frame_valid, frame_data and frame_id stay stable;
  - address stays 8'hE0;
  - no 8'hFF is issued until acceptance.
- rstn is pulsed low at byte 4 of a slave 3 read:
  - address = 8'hE0 and frame_valid = 0 immediately;
  - after release of reset, slave 3 (still low) is re-read from byte 0 and its full correct frame is delivered.
- With CS_CHECK_EN defined, a slave model with csin stuck at 0: the frame is still delivered, err = 1 from the first byte capture, and err stays 1 until reset.

Source files
------------

// File: rtl/photo_frame_master_if.sv
// Frame handshake between the photo-frame bus master and its consumer.
// One frame is a 64-bit snapshot tagged with the ID of the slave it came from.
interface photo_frame_master_if;
    logic [63:0] frame_data;
    logic [2:0]  frame_id;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output frame_data,
        output frame_id,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_id,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/photo_frame_master.sv
// Bus master that reads latched 64-bit light-curtain snapshots byte by byte.
// Defining CS_CHECK_EN enables chip-select and capture-flag checks on err.
module photo_frame_master #(
    parameter int         NSLAVE    = 7,
    parameter logic [7:0] IDLE_ADDR = 8'hE0
) (
    input  logic              clkin,
    input  logic              rstn,
    input  logic [NSLAVE-1:0] enwipein,
    input  logic [NSLAVE-1:0] csin,
    input  logic [7:0]        datain,
    output logic [7:0]        address,
    output logic              busy,
    output logic              err,
    photo_frame_master_if.master frame
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        OUT     = 3'd2,
        RELEASE = 3'd3,
        WAIT    = 3'd4
    } state_t;

    state_t            state;
    logic [NSLAVE-1:0] served;
    logic [NSLAVE-1:0] pending;
    logic [NSLAVE-1:0] sel;
    logic [2:0]        tgt;
    logic [2:0]        tgt_next;
    logic [3:0]        cnt;
    logic [55:0]       shreg;

    assign pending = ~enwipein & ~served;
    assign sel     = NSLAVE'(1) << tgt;
    assign busy    = (state != IDLE);

`ifdef CS_CHECK_EN
    logic cs_hit;
    logic enw_low;
    assign cs_hit  = |(csin & sel);
    assign enw_low = |(~enwipein & sel);
`else
    logic unused_csin;
    assign unused_csin = ^csin;
    assign err = 1'b0;
`endif

    // Lowest-numbered pending slave is served first.
    always_comb begin
        tgt_next = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if (pending[i]) tgt_next = 3'(i);
        end
    end

    // Read sequencer: address issue, byte capture, frame hand-off, release.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            address           <= IDLE_ADDR;
            served            <= '0;
            tgt               <= '0;
            cnt               <= '0;
            shreg             <= '0;
            frame.frame_data  <= '0;
            frame.frame_id    <= '0;
            frame.frame_valid <= 1'b0;
`ifdef CS_CHECK_EN
            err               <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|pending) begin
                        tgt     <= tgt_next;
                        address <= {tgt_next, 5'b00000};
                        cnt     <= 4'd1;
                        state   <= READ;
                    end else if (|served) begin
                        address <= 8'hFF;
                        state   <= RELEASE;
                    end
                end
                READ: begin
                    cnt <= cnt + 4'd1;
                    // Byte 7 stays on the bus one extra edge (cnt == 8).
                    if (cnt <= 4'd7) begin
                        address <= {tgt, 2'b00, cnt[2:0]};
                    end
                    // Slave data lags its address by two edges.
                    if (cnt >= 4'd2) begin
                        shreg <= {datain, shreg[55:8]};
`ifdef CS_CHECK_EN
                        if (!cs_hit) err <= 1'b1;
`endif
                    end
                    if (cnt == 4'd9) begin
                        frame.frame_data  <= {datain, shreg};
                        frame.frame_id    <= tgt;
                        frame.frame_valid <= 1'b1;
                        served            <= served | sel;
                        address           <= IDLE_ADDR;
                        state             <= OUT;
`ifdef CS_CHECK_EN
                        if (!enw_low) err <= 1'b1;
`endif
                    end
                end
                OUT: begin
                    if (frame.frame_ready) begin
                        frame.frame_valid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                RELEASE: begin
                    address <= IDLE_ADDR;
                    served  <= '0;
                    state   <= WAIT;
                end
                // Lets the slaves' released flags settle before re-scan.
                WAIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_photo_frame_master.sv
// Directed and randomized bench for photo_frame_master with a slave bus model.
// Snapshots come from an array; frame order is the ascending set bits of each drop.
module tb_photo_frame_master;

    localparam int NS = 7;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [NS-1:0] enw = '1;
    logic [NS-1:0] csq = '0;
    logic [NS-1:0] cs_stuck;
    logic [NS-1:0] csin_bus;
    logic [NS-1:0] drop_mask;
    logic [7:0]    dq = 8'h00;
    logic [7:0]    address;
    logic          busy;
    logic          err;
    logic [63:0]   snap [NS];

    int vectors = 0;
    int miscompares = 0;
    int ff_cycles = 0;
    int ff_long = 0;
    logic prev_ff = 1'b0;

    photo_frame_master_if fif();

    assign csin_bus = csq & ~cs_stuck;

    photo_frame_master #(.NSLAVE(NS), .IDLE_ADDR(8'hE0)) dut (
        .clkin    (clk),
        .rstn     (rstn),
        .enwipein (enw),
        .csin     (csin_bus),
        .datain   (dq),
        .address  (address),
        .busy     (busy),
        .err      (err),
        .frame    (fif)
    );

    always #5 clk = ~clk;

    // Slave model: registered data/cs on address, flags released by 8'hFF.
    always @(posedge clk) begin
        if (address == 8'hFF) enw <= '1;
        else enw <= enw & ~drop_mask;
        if (int'(address[7:5]) < NS)
            dq <= snap[address[7:5]][{address[2:0], 3'b000} +: 8];
        else
            dq <= 8'h00;
        for (int i = 0; i < NS; i++) csq[i] <= (address[7:5] == 3'(i));
    end

    // Counts 8'hFF cycles and flags any broadcast longer than one cycle.
    always @(negedge clk) begin
        if (address == 8'hFF) begin
            ff_cycles <= ff_cycles + 1;
            if (prev_ff) ff_long <= ff_long + 1;
        end
        prev_ff <= (address == 8'hFF);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop(input logic [NS-1:0] m);
        drop_mask = m;
        @(negedge clk);
        drop_mask = '0;
    endtask

    task automatic wait_addr(input logic [7:0] a, input string tag);
        int n = 0;
        while (address !== a && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(address), 64'(a));
    endtask

    task automatic get_frame(input int id);
        int n = 0;
        while (fif.frame_valid !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("frame_seen", 64'(fif.frame_valid), 64'(1));
        chk("frame_id", 64'(fif.frame_id), 64'(id));
        chk("frame_data", fif.frame_data, snap[id]);
        @(negedge clk);
    endtask

    task automatic rand_snaps();
        for (int i = 0; i < NS; i++) snap[i] = {$urandom, $urandom};
    endtask

    initial begin
        int ff0;
        logic [7:0] ea;
        logic [63:0] d0;
        logic [NS-1:0] m;

        drop_mask = '0;
        cs_stuck = '0;
        fif.frame_ready = 1'b1;
        rand_snaps();

        // Reset state.
        cyc(2);
        chk("rst_addr", 64'(address), 64'hE0);
        chk("rst_valid", 64'(fif.frame_valid), 64'(0));
        chk("rst_data", fif.frame_data, 64'h0);
        chk("rst_id", 64'(fif.frame_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rstn = 1'b1;
        cyc(3);
        chk("idle_addr", 64'(address), 64'hE0);

        // Single slave 2: exact address sequence, latency and release.
        snap[2] = 64'h0123_4567_89AB_CDEF;
        ff0 = ff_cycles;
        drop(7'b0000100);
        wait_addr(8'h40, "s1_start");
        for (int k = 0; k <= 12; k++) begin
            if (k <= 7) ea = 8'h40 + 8'(k);
            else if (k == 8) ea = 8'h47;
            else if (k == 11) ea = 8'hFF;
            else ea = 8'hE0;
            chk("s1_addr", 64'(address), 64'(ea));
            chk("s1_valid", 64'(fif.frame_valid), 64'(k == 9));
            if (k == 9) begin
                chk("s1_data", fif.frame_data, 64'h0123_4567_89AB_CDEF);
                chk("s1_id", 64'(fif.frame_id), 64'(2));
            end
            @(negedge clk);
        end
        cyc(3);
        chk("s1_ff", 64'(ff_cycles - ff0), 64'(1));
        chk("s1_busy", 64'(busy), 64'(0));

        // Slaves 0 and 5 together: ID order, single release.
        rand_snaps();
        ff0 = ff_cycles;
        drop(7'b0100001);
        get_frame(0);
        chk("s2_noff", 64'(ff_cycles - ff0), 64'(0));
        get_frame(5);
        cyc(6);
        chk("s2_ff", 64'(ff_cycles - ff0), 64'(1));

        // Slave 4 arrives while slave 1 is being read.
        rand_snaps();
        ff0 = ff_cycles;
        drop(7'b0000010);
        wait_addr(8'h20, "s3_start");
        cyc(2);
        drop(7'b0010000);
        get_frame(1);
        chk("s3_noff", 64'(ff_cycles - ff0), 64'(0));
        get_frame(4);
        cyc(6);
        chk("s3_ff", 64'(ff_cycles - ff0), 64'(1));

        // Consumer stalls for 5 cycles.
        rand_snaps();
        ff0 = ff_cycles;
        fif.frame_ready = 1'b0;
        drop(7'b1000000);
        get_frame(6);
        d0 = snap[6];
        for (int k = 0; k < 5; k++) begin
            chk("s4_valid", 64'(fif.frame_valid), 64'(1));
            chk("s4_data", fif.frame_data, d0);
            chk("s4_id", 64'(fif.frame_id), 64'(6));
            chk("s4_addr", 64'(address), 64'hE0);
            chk("s4_noff", 64'(ff_cycles - ff0), 64'(0));
            @(negedge clk);
        end
        fif.frame_ready = 1'b1;
        @(negedge clk);
        chk("s4_drop", 64'(fif.frame_valid), 64'(0));
        cyc(6);
        chk("s4_ff", 64'(ff_cycles - ff0), 64'(1));

        // Reset during byte 4 of a slave 3 read.
        rand_snaps();
        ff0 = ff_cycles;
        drop(7'b0001000);
        wait_addr(8'h64, "s5_byte4");
        rstn = 1'b0;
        #1;
        chk("s5_rst_addr", 64'(address), 64'hE0);
        chk("s5_rst_valid", 64'(fif.frame_valid), 64'(0));
        chk("s5_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        wait_addr(8'h60, "s5_reread");
        get_frame(3);
        cyc(6);
        chk("s5_ff", 64'(ff_cycles - ff0), 64'(1));

`ifdef CS_CHECK_EN
        // Chip-select stuck low on slave 2.
        rand_snaps();
        cs_stuck = 7'b0000100;
        drop(7'b0000100);
        wait_addr(8'h40, "cs_start");
        @(negedge clk);
        chk("cs_err_pre", 64'(err), 64'(0));
        @(negedge clk);
        chk("cs_err_set", 64'(err), 64'(1));
        get_frame(2);
        cyc(6);
        chk("cs_err_sticky", 64'(err), 64'(1));
        cs_stuck = '0;
        rstn = 1'b0;
        #1;
        chk("cs_err_rst", 64'(err), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        cyc(2);
`endif

        // Random drop patterns, frames expected in ascending ID order.
        for (int r = 0; r < 8; r++) begin
            rand_snaps();
            m = NS'($urandom_range(1, (1 << NS) - 1));
            ff0 = ff_cycles;
            drop(m);
            for (int i = 0; i < NS; i++) begin
                if (m[i]) get_frame(i);
            end
            cyc(6);
            chk("rnd_ff", 64'(ff_cycles - ff0), 64'(1));
            chk("rnd_released", 64'(enw), 64'((1 << NS) - 1));
        end

`ifndef CS_CHECK_EN
        chk("err_tied", 64'(err), 64'(0));
`endif
        chk("ff_width", 64'(ff_long), 64'(0));
        chk("end_busy", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
